// File: rtl/commit_trace_unit_if.sv
// Commit, trace and debug-read signals between the ROB/host side and the commit trace unit.
// The unit attaches to the slave modport. The driver side (ROB model, host or bench) uses master.
interface commit_trace_unit_if #(
    parameter int WIDTH = 31,
    parameter int REG   = 4,
    parameter int ROB   = 2
);
    logic                          commitValid;
    logic                          commitReady;
    logic [ROB:0]                  commitRob;
    logic [WIDTH:0]                commitPC;
    logic [REG:0]                  destCommit;
    logic [WIDTH:0]                result;
    logic                          regCommit;
    logic                          controlFlow;
    logic                          clearError;
    logic [REG:0]                  rdAddr;
    logic [WIDTH:0]                rdData;
    logic                          traceValid;
    logic                          traceReady;
    logic [2*(WIDTH+1)+REG+1:0]    traceData;
    logic [31:0]                   retiredCount;
    logic                          orderError;

    modport slave (
        input  commitValid, commitRob, commitPC, destCommit, result, regCommit,
               controlFlow, clearError, rdAddr, traceReady,
        output commitReady, rdData, traceValid, traceData, retiredCount, orderError
    );

    modport master (
        output commitValid, commitRob, commitPC, destCommit, result, regCommit,
               controlFlow, clearError, rdAddr, traceReady,
        input  commitReady, rdData, traceValid, traceData, retiredCount, orderError
    );
endinterface

// File: rtl/commit_trace_unit.sv
// Generic FIFO: stores records in order and shows the oldest one at the head.
// Latency: a push is visible at the head one cycle later. Backpressure: full_o is raised and the producer must stop.
module fifo #(
    parameter int W         = 8,
    parameter int DEPTH_LOG = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_vld_i,
    input  logic [W-1:0] push_dat_i,
    output logic         full_o,
    output logic         pop_vld_o,
    input  logic         pop_rdy_i,
    output logic [W-1:0] pop_dat_o
);
    localparam int DEPTH = 2**DEPTH_LOG;

    logic [W-1:0]       mem_q [DEPTH];
    logic [DEPTH_LOG:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG:0] rd_ptr_q, rd_ptr_d;
    logic               empty, push, pop;

    // The extra pointer bit separates the full case from the empty case when the low bits are equal.
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[DEPTH_LOG-1:0] == rd_ptr_q[DEPTH_LOG-1:0]) &&
                       (wr_ptr_q[DEPTH_LOG] != rd_ptr_q[DEPTH_LOG]);
    assign push      = push_vld_i && !full_o;
    assign pop       = pop_rdy_i && !empty;
    assign pop_vld_o = !empty;
    assign pop_dat_o = mem_q[rd_ptr_q[DEPTH_LOG-1:0]];
    assign wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d  = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[DEPTH_LOG-1:0]] <= push_dat_i;
        end
    end
endmodule

// Retires ROB commits into the architectural register file, checks tag order and emits trace records.
// Latency: a commit is visible on rdData, retiredCount and the trace head one cycle after acceptance.
// Backpressure: commitReady drops while the trace FIFO is full, during reset, or after an order error (HALT).
module commit_trace_unit #(
    parameter int WIDTH     = 31,
    parameter int REG       = 4,
    parameter int ROB       = 2,
    parameter int DEPTH_LOG = 3
) (
    input  logic              clk,
    input  logic              globalReset,
    commit_trace_unit_if.slave bus
);
    localparam int NREG = 2**(REG+1);
    localparam int TW   = 2*(WIDTH+1) + REG + 2;

    typedef enum logic [1:0] {RESYNC, RUN, HALT} state_t;

    state_t         state_q, state_d;
    logic [ROB:0]   exp_tag_q, exp_tag_d;
    logic           order_error_q, order_error_d;
    logic [31:0]    retired_q, retired_d;
    logic [WIDTH:0] regs_q [NREG];

    logic           fifo_full;
    logic           commit_rdy;
    logic           accept;
    logic [TW-1:0]  trace_dat;

    // Ready is independent of traceReady: a pop never makes room for a push in the same cycle.
    assign commit_rdy       = globalReset && !fifo_full && (state_q != HALT);
    assign accept           = bus.commitValid && commit_rdy;
    assign bus.commitReady  = commit_rdy;
    assign bus.orderError   = order_error_q;
    assign bus.retiredCount = retired_q;
    assign bus.rdData       = (bus.rdAddr == '0) ? '0 : regs_q[bus.rdAddr];
    assign trace_dat        = {bus.commitPC, bus.destCommit, bus.regCommit, bus.result};
    assign retired_d        = accept ? retired_q + 32'd1 : retired_q;

    always_comb begin
        state_d       = state_q;
        exp_tag_d     = exp_tag_q;
        order_error_d = order_error_q;
        case (state_q)
            RESYNC: begin
                if (accept) begin
                    exp_tag_d = bus.commitRob + 1'b1;
                    if (!bus.controlFlow) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    if (bus.commitRob == exp_tag_q) begin
                        exp_tag_d = exp_tag_q + 1'b1;
                        // After a flush the ROB restarts allocation from an arbitrary tag.
                        if (bus.controlFlow) begin
                            state_d = RESYNC;
                        end
                    end else begin
                        order_error_d = 1'b1;
                        state_d       = HALT;
                    end
                end
            end
            HALT: begin
                if (bus.clearError) begin
                    order_error_d = 1'b0;
                    state_d       = RESYNC;
                end
            end
            default: state_d = RESYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!globalReset) begin
            state_q       <= RESYNC;
            exp_tag_q     <= '0;
            order_error_q <= 1'b0;
            retired_q     <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            exp_tag_q     <= exp_tag_d;
            order_error_q <= order_error_d;
            retired_q     <= retired_d;
            if (accept && bus.regCommit && (bus.destCommit != '0)) begin
                regs_q[bus.destCommit] <= bus.result;
            end
        end
    end

    fifo #(
        .W         (TW),
        .DEPTH_LOG (DEPTH_LOG)
    ) u_trace_fifo (
        .clk        (clk),
        .rst_n      (globalReset),
        .push_vld_i (accept),
        .push_dat_i (trace_dat),
        .full_o     (fifo_full),
        .pop_vld_o  (bus.traceValid),
        .pop_rdy_i  (bus.traceReady),
        .pop_dat_o  (bus.traceData)
    );
endmodule
